// File: rtl/dpram_sweep.sv
// True dual-port byte-writable RAM with request/valid handshake, 1- or 2-cycle read
// latency, port-1-wins write collisions, selectable read-during-write and a post-reset fill sweep.
module dpram_sweep #(
    parameter int                   Bufsz   = 1024,
    parameter int                   Wordsz  = 32,
    parameter int                   Bytesz  = 8,
    parameter int                   Addrsz  = $clog2(Bufsz),
    parameter int                   Bpw     = Wordsz / Bytesz,
    parameter int                   Latency = 1,
    parameter int                   Rdw     = 0,
    parameter int                   Clear   = 1,
    parameter logic [Wordsz-1:0]    Fill    = {Wordsz{1'b0}}
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              BUSY,
    input  logic              EN_1,
    input  logic              EN_2,
    input  logic [Addrsz-1:0] ADDR_1,
    input  logic [Addrsz-1:0] ADDR_2,
    input  logic [Bpw-1:0]    W_SEL_1,
    input  logic [Bpw-1:0]    W_SEL_2,
    input  logic [Wordsz-1:0] IN_1,
    input  logic [Wordsz-1:0] IN_2,
    output logic [Wordsz-1:0] OUT_1,
    output logic [Wordsz-1:0] OUT_2,
    output logic              VALID_1,
    output logic              VALID_2
);

    logic [Wordsz-1:0] mem_r [Bufsz];
    logic              busy_r;
    logic [Addrsz-1:0] sweep_cnt_r;
    logic              acc1_s;
    logic              acc2_s;
    logic              same_addr_s;
    logic [Wordsz-1:0] old1_s;
    logic [Wordsz-1:0] old2_s;
    logic [Wordsz-1:0] mid1_s;
    logic [Wordsz-1:0] mid2_s;
    logic [Wordsz-1:0] post1_s;
    logic [Wordsz-1:0] post2_s;
    logic [Wordsz-1:0] rd1_s;
    logic [Wordsz-1:0] rd2_s;
    logic              stg_vld1_r;
    logic              stg_vld2_r;
    logic [Wordsz-1:0] stg_dat1_r;
    logic [Wordsz-1:0] stg_dat2_r;

    function automatic logic [Wordsz-1:0] merge_word(
        input logic [Wordsz-1:0] base,
        input logic [Bpw-1:0]    wsel,
        input logic [Wordsz-1:0] din
    );
        logic [Wordsz-1:0] res;
        res = base;
        for (int i = 0; i < Bpw; i++) begin
            if (wsel[i]) begin
                res[i*Bytesz +: Bytesz] = din[i*Bytesz +: Bytesz];
            end else begin
                res[i*Bytesz +: Bytesz] = base[i*Bytesz +: Bytesz];
            end
        end
        return res;
    endfunction

    assign BUSY = busy_r;

    // Request acceptance and post-write word as seen by each port (port 1 applied last so it wins)
    always_comb begin
        acc1_s      = EN_1 & ~busy_r & ~RST;
        acc2_s      = EN_2 & ~busy_r & ~RST;
        same_addr_s = (ADDR_1 == ADDR_2);
        old1_s      = mem_r[ADDR_1];
        old2_s      = mem_r[ADDR_2];
        mid1_s      = (acc2_s && same_addr_s) ? merge_word(old1_s, W_SEL_2, IN_2) : old1_s;
        post1_s     = acc1_s ? merge_word(mid1_s, W_SEL_1, IN_1) : mid1_s;
        mid2_s      = acc2_s ? merge_word(old2_s, W_SEL_2, IN_2) : old2_s;
        post2_s     = (acc1_s && same_addr_s) ? merge_word(mid2_s, W_SEL_1, IN_1) : mid2_s;
        rd1_s       = (Rdw == 1) ? post1_s : old1_s;
        rd2_s       = (Rdw == 1) ? post2_s : old2_s;
    end

    // Sweep sequencer: BUSY drops on the edge that fills the last word
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy_r      <= (Clear != 0);
            sweep_cnt_r <= {Addrsz{1'b0}};
        end else if (busy_r) begin
            sweep_cnt_r <= sweep_cnt_r + {{(Addrsz-1){1'b0}}, 1'b1};
            if (sweep_cnt_r == Addrsz'(Bufsz - 1)) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= 1'b1;
            end
        end else begin
            busy_r      <= 1'b0;
            sweep_cnt_r <= sweep_cnt_r;
        end
    end

    // Storage array: sweep fill, or per-lane writes with port 2 issued before port 1
    always_ff @(posedge CLK) begin
        if (busy_r && !RST) begin
            mem_r[sweep_cnt_r] <= Fill;
        end else begin
            for (int i = 0; i < Bpw; i++) begin
                if (acc2_s && W_SEL_2[i]) begin
                    mem_r[ADDR_2][i*Bytesz +: Bytesz] <= IN_2[i*Bytesz +: Bytesz];
                end
                if (acc1_s && W_SEL_1[i]) begin
                    mem_r[ADDR_1][i*Bytesz +: Bytesz] <= IN_1[i*Bytesz +: Bytesz];
                end
            end
        end
    end

    // Read pipeline: stage captures at the accepting edge, outputs hold when no result
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stg_vld1_r <= 1'b0;
            stg_vld2_r <= 1'b0;
            stg_dat1_r <= {Wordsz{1'b0}};
            stg_dat2_r <= {Wordsz{1'b0}};
            VALID_1    <= 1'b0;
            VALID_2    <= 1'b0;
            OUT_1      <= {Wordsz{1'b0}};
            OUT_2      <= {Wordsz{1'b0}};
        end else begin
            stg_vld1_r <= acc1_s;
            stg_vld2_r <= acc2_s;
            if (acc1_s) stg_dat1_r <= rd1_s;
            if (acc2_s) stg_dat2_r <= rd2_s;
            if (Latency == 2) begin
                VALID_1 <= stg_vld1_r;
                VALID_2 <= stg_vld2_r;
                if (stg_vld1_r) OUT_1 <= stg_dat1_r;
                if (stg_vld2_r) OUT_2 <= stg_dat2_r;
            end else begin
                VALID_1 <= acc1_s;
                VALID_2 <= acc2_s;
                if (acc1_s) OUT_1 <= rd1_s;
                if (acc2_s) OUT_2 <= rd2_s;
            end
        end
    end

endmodule

// File: tb/tb_dpram_sweep.sv
// Scoreboard bench for dpram_sweep: one instance at latency 1 / old-data RDW,
// one at latency 2 / new-data RDW, both driven with the same stimulus.
module tb_dpram_sweep;

    localparam int          BUFSZ = 16;
    localparam logic [31:0] FILL  = 32'hA5A5A5A5;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        en_1, en_2;
    logic [3:0]  addr_1, addr_2, w_sel_1, w_sel_2;
    logic [31:0] in_1, in_2;
    logic        busy_a, busy_b;
    logic        valid_a1, valid_a2, valid_b1, valid_b2;
    logic [31:0] out_a1, out_a2, out_b1, out_b2;

    exp_t        exp_q [4][$];
    logic [31:0] mdl [BUFSZ];
    logic [31:0] last_out [4];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          sweep_left = 0;

    dpram_sweep #(.Bufsz(BUFSZ), .Latency(1), .Rdw(0), .Clear(1), .Fill(FILL)) dut_a (
        .CLK(clk), .RST(rst), .BUSY(busy_a),
        .EN_1(en_1), .EN_2(en_2), .ADDR_1(addr_1), .ADDR_2(addr_2),
        .W_SEL_1(w_sel_1), .W_SEL_2(w_sel_2), .IN_1(in_1), .IN_2(in_2),
        .OUT_1(out_a1), .OUT_2(out_a2), .VALID_1(valid_a1), .VALID_2(valid_a2)
    );

    dpram_sweep #(.Bufsz(BUFSZ), .Latency(2), .Rdw(1), .Clear(1), .Fill(FILL)) dut_b (
        .CLK(clk), .RST(rst), .BUSY(busy_b),
        .EN_1(en_1), .EN_2(en_2), .ADDR_1(addr_1), .ADDR_2(addr_2),
        .W_SEL_1(w_sel_1), .W_SEL_2(w_sel_2), .IN_1(in_1), .IN_2(in_2),
        .OUT_1(out_b1), .OUT_2(out_b2), .VALID_1(valid_b1), .VALID_2(valid_b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] lane_merge(input logic [31:0] base, input logic [3:0] ws,
                                               input logic [31:0] din);
        logic [31:0] r;
        r = base;
        for (int i = 0; i < 4; i++) if (ws[i]) r[i*8 +: 8] = din[i*8 +: 8];
        return r;
    endfunction

    task automatic check_port(input int idx, input string tag, input logic v, input logic [31:0] o);
        if (exp_q[idx].size() > 0 && exp_q[idx][0].due == cyc) begin
            chk({tag, "_valid"}, 32'(v), 32'd1);
            chk({tag, "_data"}, o, exp_q[idx][0].data);
            last_out[idx] = exp_q[idx][0].data;
            exp_q[idx].delete(0);
        end else begin
            chk({tag, "_valid"}, 32'(v), 32'd0);
            chk({tag, "_hold"}, o, last_out[idx]);
        end
    endtask

    task automatic check_reset();
        chk("rst_busy_a", 32'(busy_a), 32'd1);
        chk("rst_busy_b", 32'(busy_b), 32'd1);
        chk("rst_valid_a", {30'd0, valid_a1, valid_a2}, 32'd0);
        chk("rst_valid_b", {30'd0, valid_b1, valid_b2}, 32'd0);
        chk("rst_out_a1", out_a1, 32'd0);
        chk("rst_out_a2", out_a2, 32'd0);
        chk("rst_out_b1", out_b1, 32'd0);
        chk("rst_out_b2", out_b2, 32'd0);
        for (int i = 0; i < 4; i++) last_out[i] = 32'd0;
    endtask

    task automatic step(input logic e1, input logic [3:0] a1, input logic [3:0] ws1, input logic [31:0] d1,
                        input logic e2, input logic [3:0] a2, input logic [3:0] ws2, input logic [31:0] d2);
        logic [31:0] old1, old2, new1, new2;
        en_1 = e1; addr_1 = a1; w_sel_1 = ws1; in_1 = d1;
        en_2 = e2; addr_2 = a2; w_sel_2 = ws2; in_2 = d2;
        if (sweep_left > 0) begin
            mdl[BUFSZ - sweep_left] = FILL;
            sweep_left--;
        end else begin
            old1 = mdl[a1];
            old2 = mdl[a2];
            if (e2) mdl[a2] = lane_merge(mdl[a2], ws2, d2);
            if (e1) mdl[a1] = lane_merge(mdl[a1], ws1, d1);
            new1 = mdl[a1];
            new2 = mdl[a2];
            if (e1) begin
                exp_q[0].push_back('{due: cyc + 1, data: old1});
                exp_q[2].push_back('{due: cyc + 2, data: new1});
            end
            if (e2) begin
                exp_q[1].push_back('{due: cyc + 1, data: old2});
                exp_q[3].push_back('{due: cyc + 2, data: new2});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("busy_a", 32'(busy_a), 32'(sweep_left > 0));
        chk("busy_b", 32'(busy_b), 32'(sweep_left > 0));
        check_port(0, "a1", valid_a1, out_a1);
        check_port(1, "a2", valid_a2, out_a2);
        check_port(2, "b1", valid_b1, out_b1);
        check_port(3, "b2", valid_b2, out_b2);
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        en_1 = 1'b0; en_2 = 1'b0; addr_1 = 4'd0; addr_2 = 4'd0;
        w_sel_1 = 4'd0; w_sel_2 = 4'd0; in_1 = 32'd0; in_2 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset();
        rst = 1'b0;
        sweep_left = BUFSZ;
        repeat (7) idle();

        // Reset in the middle of the sweep restarts it from address 0
        rst = 1'b1;
        #1;
        check_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset();
        rst = 1'b0;
        sweep_left = BUFSZ;
        for (int k = 0; k < BUFSZ; k++)
            step(k[0], 4'(k), 4'hF, 32'h0DD00000 + k, 1'b1, 4'(15 - k), 4'hF, 32'hFFFFFFFF);

        for (int k = 0; k < BUFSZ; k++)
            step(1'b1, 4'(k), 4'h0, 32'd0, 1'b1, 4'(15 - k), 4'h0, 32'd0);
        repeat (2) idle();

        // Byte-lane write over zero
        step(1'b1, 4'd3, 4'hF, 32'd0, 1'b1, 4'd5, 4'hF, 32'd0);
        step(1'b1, 4'd3, 4'b0101, 32'h11223344, 1'b0, 4'd0, 4'h0, 32'd0);
        step(1'b1, 4'd3, 4'h0, 32'd0, 1'b0, 4'd0, 4'h0, 32'd0);

        // Collision on address 5, then read it back from port 2
        step(1'b1, 4'd5, 4'b0011, 32'hAAAAAAAA, 1'b1, 4'd5, 4'b0110, 32'hBBBBBBBB);
        step(1'b0, 4'd0, 4'h0, 32'd0, 1'b1, 4'd5, 4'h0, 32'd0);

        // Read-during-write across ports, then a plain read
        step(1'b1, 4'd9, 4'hF, 32'h12345678, 1'b0, 4'd0, 4'h0, 32'd0);
        step(1'b1, 4'd9, 4'hF, 32'hCAFEF00D, 1'b1, 4'd9, 4'h0, 32'd0);
        step(1'b1, 4'd9, 4'h0, 32'd0, 1'b1, 4'd9, 4'h0, 32'd0);

        // A write one cycle after a read must not disturb the in-flight result
        step(1'b1, 4'd9, 4'h0, 32'd0, 1'b0, 4'd0, 4'h0, 32'd0);
        step(1'b0, 4'd0, 4'h0, 32'd0, 1'b1, 4'd9, 4'hF, 32'h0BADBEEF);
        step(1'b1, 4'd9, 4'h0, 32'd0, 1'b0, 4'd0, 4'h0, 32'd0);

        // Distinct data everywhere, then back-to-back reads on both ports
        for (int k = 0; k < 8; k++)
            step(1'b1, 4'(k), 4'hF, 32'h10000000 + k, 1'b1, 4'(8 + k), 4'hF, 32'h20000000 + k);
        for (int k = 0; k < 8; k++)
            step(1'b1, 4'(k), 4'h0, 32'd0, 1'b1, 4'(8 + k), 4'h0, 32'd0);
        repeat (3) idle();

        for (int i = 0; i < 4; i++) chk("drain", 32'(exp_q[i].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dpram_sweep.md
Name: dpram_sweep

Overview:
- Single-clock, true dual-port, byte-writable RAM.
- Adds four things a plain dual-port RAM lacks: configurable read latency, per-port request/valid signalling, deterministic write-collision resolution, and selectable read-during-write semantics.
- Adds a post-reset clear sweep that fills every word with a constant.
- Serves as the general-purpose on-chip buffer for caches, register files and scratch memory where both ports run on the core clock.

Parameters:
- Bufsz, 1024, number of words.
- Wordsz, 32, bits per word.
- Bytesz, 8, bits per write-enable slice; Wordsz must be a multiple of Bytesz.
- Addrsz, $clog2(Bufsz), address width (derived).
- Bpw, Wordsz/Bytesz, byte lanes per word (derived).
- Latency, 1, read latency in cycles; legal values 1 or 2. Value 2 adds an output register stage.
- Rdw, 0, read-during-write result. 0 = old word returned; 1 = new (merged) word returned.
- Clear, 1, when 1 the sweep runs after reset; when 0 there is no sweep.
- Fill, 0, Wordsz-bit value written by the sweep.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- BUSY  out  1  high while the clear sweep is in progress; requests are ignored while high.
- EN_1, EN_2  in  1  port request strobe.
- ADDR_1, ADDR_2  in  Addrsz  word address.
- W_SEL_1, W_SEL_2  in  Bpw  byte write enables; only honoured with EN high.
- IN_1, IN_2  in  Wordsz  write data.
- OUT_1, OUT_2  out  Wordsz  read data.
- VALID_1, VALID_2  out  1  OUT_n carries the result of a request issued Latency cycles earlier.

Behaviour:
Reset:
- RST asserted, asynchronously: OUT_n=0, VALID_n=0, all pipeline valids cleared, sweep counter=0.
- BUSY=1 if Clear=1, else BUSY=0.
- Memory contents are not reset directly.

Clear sweep (Clear=1):
- Starts on the first rising edge after RST deasserts.
- Writes Fill to address k on cycle k, k = 0..Bufsz-1.
- BUSY falls on the edge that writes address Bufsz-1, so the first request is accepted Bufsz cycles after reset release.
- RST asserted mid-sweep: counter returns to 0 and the sweep restarts from 0 once RST deasserts.

Request acceptance:
- A port request is accepted when EN_n=1 and BUSY=0.
- Every accepted request performs a read. A request with W_SEL_n=0 is a pure read.
- Ignored requests (BUSY=1 or EN_n=0) do not write and produce no VALID pulse.

Reads:
- Latency=1: OUT_n and VALID_n update on the edge that accepts the request.
- Latency=2: OUT_n and VALID_n update one edge later.
- VALID_n is a one-cycle pulse per accepted request. Back-to-back requests give a continuous VALID.
- OUT_n holds its last value when VALID_n=0.

Writes:
- For each lane i with W_SEL_n[i]=1, memory[ADDR_n][Bytesz*i +: Bytesz] takes IN_n lane i at the accepting edge.

Write collision (both ports write the same address in the same cycle):
- Resolved per lane. A lane written by both ports takes port 1 data.
- A lane written by only one port takes that port's data.

Read-during-write, same address, same cycle; applies both within a port and across ports:
- Rdw=0: OUT returns the pre-write word.
- Rdw=1: OUT returns the post-write word after collision resolution. Unwritten lanes show the old value.

Concurrent reads: both ports may read any addresses simultaneously, including the same address; no stall.

Latency=2 timing: the forwarded or old value is captured at the accepting edge. A write issued one cycle later to the same address does not alter the in-flight result.

Test Plan:
- Sweep: Bufsz=16, Clear=1, Fill=32'hA5A5A5A5, release RST -> BUSY high exactly 16 cycles. Reads of addresses 0..15 after that return A5A5A5A5 with VALID 1 cycle later (Latency=1).
- Mid-sweep reset: assert RST at sweep cycle 7 -> BUSY stays 1, outputs 0. After release, BUSY lasts a further full 16 cycles. EN pulses during BUSY produce no VALID and no writes.
- Byte write: port 1 writes addr 3, IN=32'h11223344, W_SEL=4'b0101 over 0 -> read returns 32'h00220044. With Latency=2, VALID appears 2 cycles after EN.
- Collision: both ports write addr 5 with W_SEL_1=4'b0011, IN_1=32'hAAAAAAAA and W_SEL_2=4'b0110, IN_2=32'hBBBBBBBB, over 0 -> word becomes 32'h00BBAAAA.
- Read-during-write: addr 9 holds 32'h12345678; port 1 writes 32'hCAFEF00D (all lanes) while port 2 reads addr 9 -> Rdw=0 gives OUT_2=12345678, Rdw=1 gives OUT_2=CAFEF00D. A subsequent read gives CAFEF00D in both modes.
- Throughput: 8 back-to-back reads on both ports to distinct addresses -> VALID_1 and VALID_2 high for 8 consecutive cycles with correct in-order data.
